// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with tear-free frame loading.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iLoad,
  input  logic [15:0] iData,
  input  logic [3:0]  iDigitEn,
  output logic        oBusy,
  output logic        oAck,
  output logic [3:0]  oC0,
  output logic [3:0]  oC1,
  output logic [3:0]  oC2,
  output logic [3:0]  oC3,
  output logic        oS1,
  output logic        oS0,
  output logic [3:0]  oAn
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, PENDING} loadState_t;

  loadState_t  state, stateNext;
  logic [CW-1:0] preCnt;
  logic        tick;
  logic        loadAccept;
  logic        commit;
  logic [1:0]  idx;
  logic [1:0]  nextIdx;
  logic [15:0] dataReg, shData;
  logic [3:0]  enReg, shEn;
  logic [3:0]  nextEn;
  logic [3:0]  blankMask;

  assign tick = (preCnt == LAST);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) preCnt <= '0;
    else if (tick) preCnt <= '0;
    else preCnt <= preCnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else state <= stateNext;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    stateNext  = state;
    loadAccept = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (iLoad) begin
          loadAccept = 1'b1;
          stateNext  = PENDING;
        end
      end
      PENDING: begin
        // Swap only on the 3->0 wrap so a frame is never shown half-updated.
        if (tick && idx == 2'd3) begin
          commit    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign nextIdx = idx + 2'd1;
  assign nextEn  = commit ? shEn : enReg;

`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] nextData;
  assign nextData = commit ? shData : dataReg;

  always_comb begin
    blankMask = 4'b1111;
    if (nextData[15:12] == 4'h0)  blankMask[3] = 1'b0;
    if (nextData[15:8]  == 8'h0)  blankMask[2] = 1'b0;
    if (nextData[15:4]  == 12'h0) blankMask[1] = 1'b0;
  end
`else
  assign blankMask = 4'b1111;
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      idx     <= 2'd0;
      oAn     <= 4'b1110;
      dataReg <= 16'h0000;
      enReg   <= 4'b1111;
      shData  <= 16'h0000;
      shEn    <= 4'b0000;
      oAck    <= 1'b0;
    end else begin
      oAck <= commit;
      if (loadAccept) begin
        shData <= iData;
        shEn   <= iDigitEn;
      end
      if (commit) begin
        dataReg <= shData;
        enReg   <= shEn;
      end
      // Anodes are computed from the post-edge index and enables so they
      // move in lockstep with the select lines.
      if (tick) begin
        idx <= nextIdx;
        oAn <= ~((nextEn & blankMask) & (4'b0001 << nextIdx));
      end
    end
  end

  assign oBusy = (state == PENDING);
  assign {oS1, oS0} = idx;
  assign oC0 = dataReg[3:0];
  assign oC1 = dataReg[7:4];
  assign oC2 = dataReg[11:8];
  assign oC3 = dataReg[15:12];

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised bench for display_scan_ctrl with a frame-level reference model
// plus literal checkpoints; a SCAN_DIV=1 instance covers the degenerate divider.
module tb_display_scan_ctrl;

  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iLoad = 1'b0;
  logic [15:0] iData = 16'h0;
  logic [3:0]  iDigitEn = 4'h0;
  logic        oBusy, oAck, oS1, oS0;
  logic [3:0]  oC0, oC1, oC2, oC3, oAn;

  logic        iLoad1 = 1'b0;
  logic [15:0] iData1 = 16'h0;
  logic [3:0]  iDigitEn1 = 4'h0;
  logic        busy1, ack1, s1b, s0b;
  logic [3:0]  c0b, c1b, c2b, c3b, an1;

  int nTotal = 0;
  int nBad = 0;
  bit cmpEn = 1'b0;

  display_scan_ctrl #(.SCAN_DIV(DIV)) dut (
    .iClk(iClk), .iRst(iRst), .iLoad(iLoad), .iData(iData), .iDigitEn(iDigitEn),
    .oBusy(oBusy), .oAck(oAck), .oC0(oC0), .oC1(oC1), .oC2(oC2), .oC3(oC3),
    .oS1(oS1), .oS0(oS0), .oAn(oAn)
  );

  display_scan_ctrl #(.SCAN_DIV(1)) dut1 (
    .iClk(iClk), .iRst(iRst), .iLoad(iLoad1), .iData(iData1), .iDigitEn(iDigitEn1),
    .oBusy(busy1), .oAck(ack1), .oC0(c0b), .oC1(c1b), .oC2(c2b), .oC3(c3b),
    .oS1(s1b), .oS0(s0b), .oAn(an1)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: time since reset in clock edges; the index is that count
  // divided into slots, and a frame boundary is every 4*DIV edges.
  int          mT;
  bit          mPend, mAck, wasPend;
  logic [15:0] mPData, mCData;
  logic [3:0]  mPEn, mCEn;

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mT = 0; mPend = 0; mAck = 0;
      mPData = 16'h0; mPEn = 4'h0; mCData = 16'h0; mCEn = 4'hF;
    end else begin
      wasPend = mPend;
      mT++;
      mAck = mPend && (mT % (4 * DIV) == 0);
      if (mAck) begin
        mCData = mPData;
        mCEn = mPEn;
        mPend = 0;
      end
      if (!wasPend && iLoad) begin
        mPend = 1;
        mPData = iData;
        mPEn = iDigitEn;
      end
    end
  end

  function automatic logic [3:0] lzbMask(input logic [15:0] d);
    logic [3:0] m;
    m = 4'hF;
    for (int n = 1; n < 4; n++)
      if ((d >> (4 * n)) == 16'h0) m[n] = 1'b0;
    return m;
  endfunction

  function automatic logic [3:0] expAn(input int sel, input logic [3:0] shown);
    logic [3:0] one;
    one = 4'b0001 << sel;
    return ((shown & one) != 4'h0) ? ~one : 4'hF;
  endfunction

  always @(negedge iClk) begin
    if (cmpEn) begin
      logic [3:0] shown;
      shown = LZB ? (mCEn & lzbMask(mCData)) : mCEn;
      check("scan_sel", {30'd0, oS1, oS0}, (mT / DIV) % 4);
      check("anode", {28'd0, oAn}, {28'd0, expAn((mT / DIV) % 4, shown)});
      check("digits", {16'd0, oC3, oC2, oC1, oC0}, {16'd0, mCData});
      check("busy", {31'd0, oBusy}, {31'd0, mPend});
      check("ack", {31'd0, oAck}, {31'd0, mAck});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] en);
    iLoad = 1'b1; iData = d; iDigitEn = en;
    cyc(1);
    iLoad = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    cmpEn = 1'b1;
    iRst = 1'b0;
    #1;
    check("rst_an", {28'd0, oAn}, 32'hE);
    check("rst_sel", {30'd0, oS1, oS0}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_digits", {16'd0, oC3, oC2, oC1, oC0}, 32'h0);

    // Free-running scan, no frame loaded.
    cyc(4);  check("seq_sel1", {30'd0, oS1, oS0}, 32'd1);
             check("seq_an1", {28'd0, oAn}, LZB ? 32'hF : 32'hD);
    cyc(4);  check("seq_sel2", {30'd0, oS1, oS0}, 32'd2);
             check("seq_an2", {28'd0, oAn}, LZB ? 32'hF : 32'hB);
    cyc(4);  check("seq_sel3", {30'd0, oS1, oS0}, 32'd3);
             check("seq_an3", {28'd0, oAn}, LZB ? 32'hF : 32'h7);
    cyc(4);  check("seq_wrap", {30'd0, oS1, oS0}, 32'd0);
             check("seq_an0", {28'd0, oAn}, 32'hE);

    // Load 1234 during slot 1; commit at the next 3->0 wrap (t=32).
    cyc(4);  load(16'h1234, 4'hF);
    check("busy_after_load", {31'd0, oBusy}, 32'd1);
    check("no_early_commit", {16'd0, oC3, oC2, oC1, oC0}, 32'h0);
    cyc(11);
    check("c0_1234", {28'd0, oC0}, 32'h4);
    check("c1_1234", {28'd0, oC1}, 32'h3);
    check("c2_1234", {28'd0, oC2}, 32'h2);
    check("c3_1234", {28'd0, oC3}, 32'h1);
    check("ack_pulse", {31'd0, oAck}, 32'd1);
    check("busy_clear", {31'd0, oBusy}, 32'd0);
    cyc(1);  check("ack_one_cycle", {31'd0, oAck}, 32'd0);

    // Load while busy is dropped; a later load commits on the following frame.
    cyc(3);  load(16'h5678, 4'hF);
    cyc(3);  load(16'hFFFF, 4'hF);
    cyc(7);  check("ignored_busy_load", {16'd0, oC3, oC2, oC1, oC0}, 32'h5678);
    cyc(2);  load(16'hFFFF, 4'b0101);
    cyc(13); check("second_frame", {16'd0, oC3, oC2, oC1, oC0}, 32'hFFFF);
             check("mask_slot0", {28'd0, oAn}, 32'hE);
    cyc(4);  check("mask_slot1", {28'd0, oAn}, 32'hF);
    cyc(4);  check("mask_slot2", {28'd0, oAn}, 32'hB);
    cyc(4);  check("mask_slot3", {28'd0, oAn}, 32'hF);

    // Reset mid-slot while a frame is pending.
    cyc(2);  load(16'h0070, 4'hF);
    cyc(6);
    #2 iRst = 1'b1;
    #1;
    check("arst_busy", {31'd0, oBusy}, 32'd0);
    check("arst_ack", {31'd0, oAck}, 32'd0);
    check("arst_digits", {16'd0, oC3, oC2, oC1, oC0}, 32'h0);
    check("arst_an", {28'd0, oAn}, 32'hE);
    check("arst_sel", {30'd0, oS1, oS0}, 32'd0);
    cyc(1);
    iRst = 1'b0;
    #1 check("div1_sel0", {30'd0, s1b, s0b}, 32'd0);
    for (int k = 1; k < 8; k++) begin
      cyc(1);
      check("div1_sel", {30'd0, s1b, s0b}, k % 4);
    end
    cyc(31);
    check("discarded_frame", {16'd0, oC3, oC2, oC1, oC0}, 32'h0);

    // Leading-zero case: 0070 shows digits 0 and 1 only when blanking is built in.
    load(16'h0070, 4'hF);
    cyc(9);  check("lz_commit", {16'd0, oC3, oC2, oC1, oC0}, 32'h0070);
             check("lz_slot0", {28'd0, oAn}, 32'hE);
    cyc(4);  check("lz_slot1", {28'd0, oAn}, 32'hD);
    cyc(4);  check("lz_slot2", {28'd0, oAn}, LZB ? 32'hF : 32'hB);
    cyc(4);  check("lz_slot3", {28'd0, oAn}, LZB ? 32'hF : 32'h7);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      iLoad = ($urandom_range(0, 5) == 0);
      iData = 16'($urandom);
      if ($urandom_range(0, 3) == 0) iData[15:8] = 8'h00;
      iDigitEn = 4'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 iRst = 1'b1;
        cyc(1);
        iRst = 1'b0;
      end else begin
        cyc(1);
      end
    end
    iLoad = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
